// File: rtl/bikelight_pkg.sv
// Shared mode encoding and mode-sequencing helper for the multi-LED bike light.
package bikelight_pkg;

  localparam int MODE_W = 3;

  // Encodings 5..7 are never produced by the design. If they ever appear,
  // the LED decode treats them as dark and the next press returns to OFF.
  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 3'd0,
    MODE_ON    = 3'd1,
    MODE_BLINK = 3'd2,
    MODE_DIM   = 3'd3,
    MODE_CHASE = 3'd4
  } mode_e;

  // Mode reached by one clean button press.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:   next_mode = MODE_ON;
      MODE_ON:    next_mode = MODE_BLINK;
      MODE_BLINK: next_mode = MODE_DIM;
      MODE_DIM:   next_mode = MODE_CHASE;
      MODE_CHASE: next_mode = MODE_OFF;
      default:    next_mode = MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front end: two-flop synchroniser, level debouncer and rising-edge
// detector. btn_db only follows btn_s after DEBOUNCE_CYCLES consecutive
// disagreeing samples; press is high for the single cycle after btn_db rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_db,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          btn_s;
  logic          btn_db_q;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
    end
  end

  // Accept a new level only after it has disagreed with btn_db for a full run
  // of consecutive samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db <= 1'b0;
      cnt    <= '0;
    end else if (btn_s != btn_db) begin
      if (cnt == CNT_LAST) begin
        btn_db <= btn_s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
    end
  end

  assign press = btn_db & ~btn_db_q;

endmodule

// File: rtl/bikelight_multi.sv
// Multi-channel bike light: a debounced button steps through OFF, ON, BLINK,
// DIM and CHASE; holding the button long enough forces OFF. The led bus is
// decoded purely from registered state, so it only moves on clock edges or
// on asynchronous reset. The mode output doubles as the FSM state view.
module bikelight_multi
  import bikelight_pkg::*;
#(
  parameter int N_LED           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_HALF      = 8,
  parameter int PWM_BITS        = 4,
  parameter int DIM_DUTY        = 4,
  parameter int LONG_PRESS      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn,
  output logic [N_LED-1:0]  led,
  output logic [MODE_W-1:0] mode
);

  localparam int TW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BLINK_HALF - 1);
  localparam int HW = $clog2(LONG_PRESS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_PRESS);
  localparam logic [N_LED-1:0] CHASE_INIT = N_LED'(1);

  logic                btn_db;
  logic                press;
  mode_e               mode_q;
  mode_e               mode_d;
  logic                mode_load;
  logic                long_fire;
  logic [HW-1:0]       hold_q;
  logic [TW-1:0]       tick;
  logic                phase;
  logic [N_LED-1:0]    chase;
  logic [N_LED-1:0]    chase_rot;
  logic [PWM_BITS-1:0] pwm;
  logic [31:0]         pwm_ext;
  logic                dim_on;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .btn_db(btn_db),
    .press (press)
  );

  // Long press fires on the edge the hold count reaches LONG_PRESS; after
  // that the count sits at LONG_PRESS so the same hold cannot fire again.
  assign long_fire = btn_db && !press && (hold_q == HOLD_LAST);

  // Hold counter: restarts on each press, counts while held, clears on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (press) begin
      hold_q <= '0;
    end else if (!btn_db) begin
      hold_q <= '0;
    end else if (hold_q != HOLD_SAT) begin
      hold_q <= hold_q + 1'b1;
    end
  end

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_OFF;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Mode next-state: a press advances, a long hold forces OFF.
  always_comb begin
    mode_d    = mode_q;
    mode_load = 1'b0;
    if (press) begin
      mode_d    = next_mode(mode_q);
      mode_load = 1'b1;
    end else if (long_fire) begin
      mode_d    = MODE_OFF;
      mode_load = 1'b1;
    end
  end

  // Left rotate with wrap; a single channel rotates onto itself.
  assign chase_rot = (chase << 1) | (chase >> (N_LED - 1));

  // Pattern timebase: restarts on every mode change so each pattern begins
  // from the same visible phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick  <= '0;
      phase <= 1'b1;
      chase <= CHASE_INIT;
      pwm   <= '0;
    end else if (mode_load) begin
      tick  <= '0;
      phase <= 1'b1;
      chase <= CHASE_INIT;
      pwm   <= '0;
    end else begin
      pwm <= pwm + 1'b1;
      if (tick == TICK_LAST) begin
        tick  <= '0;
        phase <= ~phase;
        chase <= chase_rot;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  // Duty values at or above the PWM period naturally compare always-true.
  assign pwm_ext = 32'(pwm);
  assign dim_on  = (pwm_ext < 32'(DIM_DUTY));

  // LED decode from registered state only.
  always_comb begin
    led = '0;
    case (mode_q)
      MODE_ON:    led = '1;
      MODE_BLINK: led = {N_LED{phase}};
      MODE_DIM:   led = {N_LED{dim_on}};
      MODE_CHASE: led = chase;
      default:    led = '0;
    endcase
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_bikelight_multi.sv
// Bench for bikelight_multi: directed button sequences, a cycle-level
// behavioural model feeding an expected queue, and literal spot checks.
module tb_bikelight_multi;

  localparam int N_LED = 4;
  localparam int DB    = 4;
  localparam int BH    = 8;
  localparam int PB    = 4;
  localparam int DUTY  = 4;
  localparam int LP    = 32;
  localparam int W     = 3 + N_LED;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             btn = 1'b0;
  logic [N_LED-1:0] led;
  logic [2:0]       mode;

  always #5 clk = ~clk;

  bikelight_multi #(
    .N_LED          (N_LED),
    .DEBOUNCE_CYCLES(DB),
    .BLINK_HALF     (BH),
    .PWM_BITS       (PB),
    .DIM_DUTY       (DUTY),
    .LONG_PRESS     (LP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn),
    .led  (led),
    .mode (mode)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  // Edges are numbered from 1 after reset; raw[e-1] is btn seen at edge e.
  // The debounced level flips at edge n when the raw samples from edges
  // n-DB-1 .. n-2 all disagree with it and at least DB edges have passed
  // since the previous flip. A press lands one edge after a rise.
  bit          raw[$];
  int          m_edge;
  int          m_last_flip;
  int          m_entry;
  int          m_press_edge;
  int          m_mode;
  bit          m_db;
  bit          m_rose;
  bit          m_armed;
  bit          m_all;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  function automatic bit raw_at(input int e);
    if (e < 1 || e > raw.size()) return 1'b0;
    return raw[e-1];
  endfunction

  function automatic logic [N_LED-1:0] model_led();
    int k;
    logic [N_LED-1:0] one;
    k   = m_edge - m_entry;
    one = 1;
    case (m_mode)
      1:       return '1;
      2:       return (((k / BH) % 2) == 0) ? '1 : '0;
      3:       return ((k % (1 << PB)) < DUTY) ? '1 : '0;
      4:       return one << ((k / BH) % N_LED);
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_edge       = 0;
    m_last_flip  = 0;
    m_entry      = 0;
    m_press_edge = 0;
    m_mode       = 0;
    m_db         = 1'b0;
    m_rose       = 1'b0;
    m_armed      = 1'b0;
    raw.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
      // clk high means an expectation is still waiting for its compare.
      exp_q.delete();
      if (clk) exp_q.push_back('0);
    end else begin
      m_edge++;
      raw.push_back(btn);
      if (m_rose) begin
        m_mode       = (m_mode + 1) % 5;
        m_entry      = m_edge;
        m_press_edge = m_edge;
        m_armed      = 1'b1;
      end else if (!m_db) begin
        m_armed = 1'b0;
      end else if (m_armed && (m_edge - m_press_edge == LP)) begin
        m_mode  = 0;
        m_entry = m_edge;
        m_armed = 1'b0;
      end
      m_rose = 1'b0;
      if (m_edge - m_last_flip >= DB) begin
        m_all = 1'b1;
        for (int j = 2; j <= DB + 1; j++) begin
          if (raw_at(m_edge - j) == m_db) m_all = 1'b0;
        end
        if (m_all) begin
          m_db        = !m_db;
          m_last_flip = m_edge;
          m_rose      = m_db;
        end
      end
      exp_q.push_back({3'(m_mode), model_led()});
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_empty t=%0t no expectation queued", $time);
    end else begin
      exp_v = exp_q.pop_front();
      if ({mode, led} !== exp_v) begin
        failures++;
        $display("FAIL cycle t=%0t mode=%0d led=%b expected mode=%0d led=%b",
                 $time, mode, led, exp_v[W-1:N_LED], exp_v[N_LED-1:0]);
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, expv);
    end
  endtask

  // Returns on the first negedge where mode shows target (entry cycle).
  task automatic wait_mode(input logic [2:0] target, input int budget);
    int n;
    n = 0;
    while (mode !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mode !== target) begin
      failures++;
      $display("FAIL wait_mode t=%0t actual=%0d expected=%0d", $time, mode, target);
    end
  endtask

  // Short clean press, then wait for the resulting mode.
  task automatic tap_to(input logic [2:0] target);
    btn = 1'b1;
    repeat (5) @(negedge clk);
    btn = 1'b0;
    wait_mode(target, 20);
  endtask

  task automatic press_to(input logic [2:0] target);
    tap_to(target);
    repeat (10) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int               seq_tab[5] = '{1, 2, 3, 4, 0};
  logic [N_LED-1:0] chase_tab[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    // Reset state
    rst_n = 1'b0;
    btn   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_mode", 32'(mode), 0);
    chk("reset_led", 32'(led), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Async reset in BLINK with the button held, then held through release
    press_to(1);
    press_to(2);
    repeat (3) @(negedge clk);
    btn = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 0);
    chk("async_rst_mode", 32'(mode), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("held_edge6_mode", 32'(mode), 0);
    @(negedge clk);
    chk("held_edge7_mode", 32'(mode), 1);
    btn = 1'b0;
    repeat (15) @(negedge clk);
    chk("held_release_mode", 32'(mode), 1);

    // Glitch rejection and minimum accepted press
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch3_mode", 32'(mode), 1);
    btn = 1'b1;
    repeat (4) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    chk("exact4_mode", 32'(mode), 2);
    repeat (10) @(negedge clk);
    chk("exact4_release_mode", 32'(mode), 2);
    press_to(3);
    press_to(4);
    press_to(0);

    // Full cycle of five presses from OFF
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1;
      repeat (10) @(negedge clk);
      btn = 1'b0;
      repeat (10) @(negedge clk);
      chk("seq_mode", 32'(mode), 32'(seq_tab[i]));
      if (i == 0) chk("seq_on_led", 32'(led), 32'hF);
      if (i == 4) chk("seq_off_led", 32'(led), 0);
    end

    // BLINK pattern from entry
    press_to(1);
    tap_to(2);
    for (int i = 0; i < 24; i++) begin
      chk("blink_led", 32'(led), (i < 8 || i >= 16) ? 32'hF : 32'h0);
      @(negedge clk);
    end

    // DIM duty from entry
    tap_to(3);
    for (int i = 0; i < 32; i++) begin
      chk("dim_led", 32'(led), ((i % 16) < 4) ? 32'hF : 32'h0);
      @(negedge clk);
    end

    // CHASE walk with wrap
    tap_to(4);
    for (int i = 0; i < 40; i++) begin
      chk("chase_led", 32'(led), 32'(chase_tab[i / 8]));
      @(negedge clk);
    end

    // Long press from ON
    press_to(0);
    press_to(1);
    btn = 1'b1;
    wait_mode(2, 20);
    repeat (31) @(negedge clk);
    chk("long_before_mode", 32'(mode), 2);
    @(negedge clk);
    chk("long_fire_mode", 32'(mode), 0);
    chk("long_fire_led", 32'(led), 0);
    repeat (21) @(negedge clk);
    chk("long_hold_mode", 32'(mode), 0);
    btn = 1'b0;
    repeat (20) @(negedge clk);
    chk("long_release_mode", 32'(mode), 0);
    chk("long_release_led", 32'(led), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net in case a wait ever stops advancing time.
  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t bench did not finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
